// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the key debouncer.
// Polarity and counter sizing live here.
package key_debounce_pkg;

  localparam logic KEY_RELEASED = 1'b1;

  function automatic int cnt_width(int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One key channel: 2-FF synchroniser,
// stability counter and clean-level flop.
module debounce_bit
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_clean,
  output logic busy
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clean_q;
  logic          clean_d;
  logic          differ;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= KEY_RELEASED;
      sync2 <= KEY_RELEASED;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign differ = (sync2 != clean_q);

  // Count consecutive disagreeing samples; accept on the last one
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    unique case (1'b1)
      !differ: begin
        cnt_d = '0;
      end
      differ && (cnt_q == CNT_LAST): begin
        clean_d = sync2;
        cnt_d   = '0;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  // Hold counter and accepted level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      clean_q <= KEY_RELEASED;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign key_clean = clean_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent
// debounce_bit per key channel.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] busy
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock    (clock),
      .reset_n  (reset_n),
      .key_raw  (key_raw[i]),
      .key_clean(key_clean[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce
// with two keys and a four-cycle window.
module tb_key_debounce;

  logic       clock;
  logic       reset_n;
  logic [1:0] key_raw;
  logic [1:0] key_clean;
  logic [1:0] busy;

  int pass_cnt;
  int total_cnt;

  key_debounce #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .key_raw  (key_raw),
    .key_clean(key_clean),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #10;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_raw = 2'b00;
    step();
    step();
    total_cnt++;
    if (key_clean !== 2'b11)
      $display("FAIL reset_clean: got %b want 11", key_clean);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 2'b00)
      $display("FAIL reset_busy: got %b want 00", busy);
    else pass_cnt++;
    #40 reset_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      total_cnt++;
      if (key_clean !== 2'b11 || busy !== 2'b00)
        $display("FAIL post_reset e%0d: clean=%b busy=%b want 11/00",
                 e, key_clean, busy);
      else pass_cnt++;
    end
    key_raw = 2'b11;
    repeat (8) step();
    total_cnt++;
    if (key_clean !== 2'b11 || busy !== 2'b00)
      $display("FAIL settle: clean=%b busy=%b want 11/00",
               key_clean, busy);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic lv [9];
    lv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      key_raw[0] = lv[i];
      step();
      total_cnt++;
      if (key_clean[0] !== 1'b1)
        $display("FAIL bounce c%0d: clean0=%b want 1",
                 i, key_clean[0]);
      else pass_cnt++;
    end
    key_raw[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (key_clean !== 2'b11)
        $display("FAIL bounce_tail c%0d: clean=%b want 11",
                 i, key_clean);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 2'b00)
      $display("FAIL bounce_busy: got %b want 00", busy);
    else pass_cnt++;
  endtask

  task automatic test_press();
    logic eb;
    logic ec;
    key_raw[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      eb = (e >= 3 && e <= 5);
      ec = (e < 6);
      total_cnt++;
      if (busy[0] !== eb)
        $display("FAIL press_busy e%0d: got %b want %b",
                 e, busy[0], eb);
      else pass_cnt++;
      total_cnt++;
      if (key_clean[0] !== ec)
        $display("FAIL press_clean e%0d: got %b want %b",
                 e, key_clean[0], ec);
      else pass_cnt++;
    end
  endtask

  task automatic test_release();
    logic ec;
    key_raw[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      ec = (e >= 6);
      total_cnt++;
      if (key_clean[0] !== ec)
        $display("FAIL release_clean e%0d: got %b want %b",
                 e, key_clean[0], ec);
      else pass_cnt++;
      total_cnt++;
      if (key_clean[1] !== 1'b1)
        $display("FAIL release_other e%0d: got %b want 1",
                 e, key_clean[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] ec;
    logic lv [9];
    key_raw = 2'b00;
    for (int e = 1; e <= 6; e++) begin
      step();
      ec = (e < 6) ? 2'b11 : 2'b00;
      total_cnt++;
      if (key_clean !== ec)
        $display("FAIL simul e%0d: got %b want %b",
                 e, key_clean, ec);
      else pass_cnt++;
    end
    lv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
           1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      key_raw[1] = lv[i];
      step();
      total_cnt++;
      if (key_clean !== 2'b00 || busy[0] !== 1'b0)
        $display("FAIL simul_bounce c%0d: clean=%b busy0=%b want 00/0",
                 i, key_clean, busy[0]);
      else pass_cnt++;
    end
    key_raw = 2'b00;
    repeat (6) step();
    total_cnt++;
    if (key_clean !== 2'b00)
      $display("FAIL simul_hold: got %b want 00", key_clean);
    else pass_cnt++;
    key_raw = 2'b11;
    repeat (8) step();
    total_cnt++;
    if (key_clean !== 2'b11 || busy !== 2'b00)
      $display("FAIL simul_release: clean=%b busy=%b want 11/00",
               key_clean, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic ec;
    key_raw[0] = 1'b0;
    repeat (4) step();
    total_cnt++;
    if (busy[0] !== 1'b1)
      $display("FAIL mid_busy_pre: got %b want 1", busy[0]);
    else pass_cnt++;
    #20 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (busy[0] !== 1'b0)
      $display("FAIL mid_busy_async: got %b want 0", busy[0]);
    else pass_cnt++;
    total_cnt++;
    if (key_clean[0] !== 1'b1)
      $display("FAIL mid_clean_async: got %b want 1",
               key_clean[0]);
    else pass_cnt++;
    #39 reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      ec = (e < 6);
      total_cnt++;
      if (key_clean[0] !== ec)
        $display("FAIL mid_repress e%0d: got %b want %b",
                 e, key_clean[0], ec);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    key_raw   = 2'b00;
    test_reset();
    test_bounce();
    test_press();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
